regfile_mport: RTL and testbench

//  Parametrised multi-port register file for the MIPS core; next generation of the 2R/1W file.
//  N registered read ports, M write ports, and a dedicated link-register write port (JAL).

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_wr_sel.sv | 38 +++
 rtl/regfile_mport.sv | 112 +++++++++++
 tb/tb_regfile_mport.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, clog2 and packed-slice helpers for the regfile_mport register file.
// Optional same-cycle read bypass is selected with REGFILE_BYPASS_EN (see regfile_mport).
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

// Port k of a packed bus whose ports are each w bits wide
`define RF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package regfile_pkg;

    localparam int unsigned ZERO_REG         = 0;
    localparam int unsigned DEFAULT_LINK_REG = 31;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v != 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/regfile_wr_sel.sv
// Combinational write select for one register entry: higher port index wins, every port beats link.
module regfile_wr_sel
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NWR     = 2,
    parameter int unsigned IDX     = 1,
    parameter bit          IS_LINK = 1'b0
) (
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                link_en,
    input  logic [XLEN-1:0]     link_addr,
    output logic                we_c,
    output logic [XLEN-1:0]     data_c,
    output logic                clr_c
);

    // Lowest priority first so later assignments override
    always_comb begin
        we_c   = 1'b0;
        data_c = '0;
        if (IS_LINK && link_en) begin
            we_c   = 1'b1;
            data_c = link_addr;
        end
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wr_en[k] && (`RF_SLICE(wr_addr, k, AW) == AW'(IDX))) begin
                we_c   = 1'b1;
                data_c = `RF_SLICE(wr_data, k, XLEN);
            end
        end
        clr_c = we_c;
    end

endmodule

// File: rtl/regfile_mport.sv
// Multi-port register file with link write port and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes (and post-edge busy) to the read ports.
module regfile_mport
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned NREGS    = 32,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned NWR      = 2,
    parameter  int unsigned LINK_REG = DEFAULT_LINK_REG,
    localparam int unsigned AW       = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                link_en,
    input  logic [XLEN-1:0]     link_addr,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy
);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;
    logic [NRD*XLEN-1:0] rd_data_q;
    logic [NRD*XLEN-1:0] rd_data_d;
    logic [NRD-1:0]      rd_busy_q;
    logic [NRD-1:0]      rd_busy_d;

    logic [NREGS-1:1]    sel_we_c;
    logic [NREGS-1:1]    sel_clr_c;
    logic [XLEN-1:0]     sel_data_c [1:NREGS-1];

    // Register 0 has no select: it is hardwired to zero
    for (genvar i = 1; i < NREGS; i++) begin : g_sel
        regfile_wr_sel #(
            .XLEN    (XLEN),
            .AW      (AW),
            .NWR     (NWR),
            .IDX     (i),
            .IS_LINK (i == LINK_REG)
        ) u_sel (
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .link_en   (link_en),
            .link_addr (link_addr),
            .we_c      (sel_we_c[i]),
            .data_c    (sel_data_c[i]),
            .clr_c     (sel_clr_c[i])
        );
    end

    // Next register and scoreboard state; a reservation beats a same-cycle clear
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (sel_we_c[i]) begin
                regs_d[i] = sel_data_c[i];
            end
            if (sel_clr_c[i]) begin
                busy_d[i] = 1'b0;
            end
            if (rsv_en && (rsv_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        regs_d[ZERO_REG] = '0;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
`ifdef REGFILE_BYPASS_EN
            `RF_SLICE(rd_data_d, j, XLEN) = regs_d[`RF_SLICE(rd_addr, j, AW)];
            rd_busy_d[j]                  = busy_d[`RF_SLICE(rd_addr, j, AW)];
`else
            `RF_SLICE(rd_data_d, j, XLEN) = regs_q[`RF_SLICE(rd_addr, j, AW)];
            rd_busy_d[j]                  = busy_q[`RF_SLICE(rd_addr, j, AW)];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mport.sv
// Self-checking bench for regfile_mport: directed vector table, then random traffic against an array model.
module tb_regfile_mport;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        le;
        logic [31:0] la;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        string       name;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                link_en;
    logic [XLEN-1:0]     link_addr;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic [31:0] m_reg  [NREGS];
    logic        m_busy [NREGS];
    vec_t        tbl [$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    regfile_mport dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_addr (link_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy)
    );

    function automatic stim_t st(input logic r, input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic le, input logic [31:0] la,
                                 input logic re, input logic [4:0] ra,
                                 input logic [4:0] rd0, input logic [4:0] rd1);
        stim_t s;
        s.rst = r;  s.we = we;
        s.wa0 = wa0; s.wd0 = wd0; s.wa1 = wa1; s.wd1 = wd1;
        s.le = le;  s.la = la;  s.re = re; s.ra = ra;
        s.rd0 = rd0; s.rd1 = rd1;
        return s;
    endfunction

    task automatic add(input stim_t s, input logic [31:0] d0, input logic [31:0] d1,
                       input logic b0, input logic b1, input string nm);
        vec_t v;
        v.s = s; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle; model computes the expected reads and its own next state from the rules
    task automatic run(input stim_t s, output logic [63:0] ed, output logic [1:0] eb);
        logic [31:0] n_reg  [NREGS];
        logic        n_busy [NREGS];
        logic [4:0]  a;
        rst       = s.rst;
        wr_en     = s.we;
        wr_addr   = {s.wa1, s.wa0};
        wr_data   = {s.wd1, s.wd0};
        link_en   = s.le;
        link_addr = s.la;
        rsv_en    = s.re;
        rsv_addr  = s.ra;
        rd_addr   = {s.rd1, s.rd0};
        n_reg  = m_reg;
        n_busy = m_busy;
        if (s.rst) begin
            for (int i = 0; i < NREGS; i++) begin
                n_reg[i]  = '0;
                n_busy[i] = 1'b0;
            end
        end else begin
            if (s.le) begin
                n_reg[31]  = s.la;
                n_busy[31] = 1'b0;
            end
            if (s.we[0] && s.wa0 != 0) begin
                n_reg[s.wa0]  = s.wd0;
                n_busy[s.wa0] = 1'b0;
            end
            if (s.we[1] && s.wa1 != 0) begin
                n_reg[s.wa1]  = s.wd1;
                n_busy[s.wa1] = 1'b0;
            end
            if (s.re && s.ra != 0) n_busy[s.ra] = 1'b1;
        end
        for (int j = 0; j < NRD; j++) begin
            a = (j == 0) ? s.rd0 : s.rd1;
            if (s.rst) begin
                ed[j*32 +: 32] = '0;
                eb[j]          = 1'b0;
            end else begin
                ed[j*32 +: 32] = BYP ? n_reg[a]  : m_reg[a];
                eb[j]          = BYP ? n_busy[a] : m_busy[a];
            end
        end
        m_reg  = n_reg;
        m_busy = n_busy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [63:0] ed;
        logic [1:0]  eb;
        stim_t       s;

        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end

        add(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, "reset_state");
        add(st(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 5),
            BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, "wr_r5");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0), 32'hDEADBEEF, 0, 0, 0, "rd_r5");
        add(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5), 0, 0, 0, 0, "rst_mid");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5), 0, 0, 0, 0, "r5_cleared");
        add(st(0, 2'b11, 3, 32'h11, 4, 32'h22, 0, 0, 0, 0, 3, 4),
            BYP ? 32'h11 : 32'h0, BYP ? 32'h22 : 32'h0, 0, 0, "dual_wr");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4), 32'h11, 32'h22, 0, 0, "dual_rd");
        add(st(0, 2'b11, 31, 32'hA, 31, 32'hB, 1, 32'hC, 0, 0, 31, 3),
            BYP ? 32'hB : 32'h0, 32'h11, 0, 0, "collide_wr");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 31), 32'hB, 32'hB, 0, 0, "collide_rd");
        add(st(0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 31, 4),
            BYP ? 32'h400 : 32'hB, 32'h22, 0, 0, "link_wr");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 31), 32'h400, 32'h400, 0, 0, "link_rd");
        add(st(0, 2'b10, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 4), 0, 32'h22, 0, 0, "r0_wr_rsv");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, "r0_rd");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0), 0, 0, BYP, 0, "rsv_r7");
        add(st(0, 2'b01, 7, 32'h77, 0, 0, 0, 0, 1, 7, 7, 0),
            BYP ? 32'h77 : 32'h0, 0, 1, 0, "wr_rsv_r7");
        add(st(0, 2'b10, 0, 0, 7, 32'h88, 0, 0, 0, 0, 7, 0),
            BYP ? 32'h88 : 32'h77, 0, !BYP, 0, "wr_r7");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7), 32'h88, 32'h88, 0, 0, "r7_free");
        add(st(0, 2'b01, 9, 32'h12, 0, 0, 0, 0, 0, 0, 9, 0),
            BYP ? 32'h12 : 32'h0, 0, 0, 0, "r9_init");
        add(st(0, 2'b01, 9, 32'h55, 0, 0, 0, 0, 0, 0, 9, 9),
            BYP ? 32'h55 : 32'h12, BYP ? 32'h55 : 32'h12, 0, 0, "bypass");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0), 32'h55, 0, 0, 0, "bypass_next");
        add(st(0, 2'b01, 31, 32'h99, 0, 0, 1, 32'h1234, 0, 0, 31, 0),
            BYP ? 32'h99 : 32'h400, 0, 0, 0, "wr_over_link");
        add(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 0), 32'h99, 0, 0, 0, "wr_over_link_rd");

        foreach (tbl[i]) begin
            run(tbl[i].s, ed, eb);
            chk($sformatf("%s.data", tbl[i].name), 64'(rd_data), {tbl[i].d1, tbl[i].d0});
            chk($sformatf("%s.busy", tbl[i].name), 64'(rd_busy), 64'({tbl[i].b1, tbl[i].b0}));
        end

        for (int n = 0; n < 600; n++) begin
            s = st(($urandom_range(0, 49) == 0), 2'($urandom), pick(), $urandom,
                   pick(), $urandom, ($urandom_range(0, 3) == 0), $urandom,
                   ($urandom_range(0, 2) == 0), pick(), pick(), pick());
            run(s, ed, eb);
            chk($sformatf("rand%0d.data", n), 64'(rd_data), ed);
            chk($sformatf("rand%0d.busy", n), 64'(rd_busy), 64'(eb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
